multiport_register_file: RTL and testbench
==========================================

Name: multiport_register_file

Overview:
- Parametrised successor to the single-write, two-read CPU register file.
- Configurable data width, register count, read-port count and write-port count.
- Adds same-cycle write-to-read bypass and an asynchronous clear.
- Adds a per-register busy scoreboard so the pipeline can detect pending writes (RAW hazards).
- Sits in the decode/writeback stages of the pipelined core.

Parameters:
- DATA_WIDTH, 32, bits per register
- NUM_REGS, 32, number of registers; register 0 is hardwired zero
- ADDR_WIDTH, 5, register address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS
- NUM_READ, 2, number of read ports (1..8)
- NUM_WRITE, 2, number of write ports (1..4)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- reg_read  input  NUM_READ*ADDR_WIDTH  read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- read_enable  input  NUM_READ  per-port read strobe; when low, that port's outputs hold
- data_read  output  NUM_READ*DATA_WIDTH  registered read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- read_busy  output  NUM_READ  registered busy flag of the address read, aligned with data_read
- reg_write  input  NUM_WRITE*ADDR_WIDTH  write addresses, packed as for reg_read
- data_write  input  NUM_WRITE*DATA_WIDTH  write data, packed
- write_enable  input  NUM_WRITE  per-port write strobe
- busy_set  input  1  mark busy_reg as having a pending write
- busy_reg  input  ADDR_WIDTH  register to mark busy
- busy_vector  output  NUM_REGS  current scoreboard, bit r = register r busy

Behaviour:
- Reset (async, immediate, regardless of clk):
  - All registers = 0.
  - data_read = 0, read_busy = 0, busy_vector = 0.
  - After deassertion, the first active edge operates normally.
- Writes:
  - At posedge, for each port w with write_enable[w], register reg_write[w] takes data_write[w].
  - Address 0 or any address >= NUM_REGS: write ignored.
- Write conflict: two enabled ports targeting the same register in one cycle -> the highest port index wins.
- Reads:
  - Latency 1 cycle. At posedge, for each port i with read_enable[i], data_read[i] loads the value of reg_read[i].
  - Bypass: if an enabled write to the same register occurs at the same edge, data_read[i] gets the winning data_write, i.e. the post-write value.
  - Address 0 or address >= NUM_REGS reads 0.
  - read_enable[i] low: data_read[i] and read_busy[i] hold their previous values.
- Scoreboard:
  - At posedge, busy_set sets bit busy_reg.
  - Any enabled write to register r clears bit r.
  - Set and clear of the same register at the same edge: set wins (a new writer has issued).
  - Bit 0 and addresses >= NUM_REGS are never set.
  - busy_vector is the registered scoreboard.
- read_busy[i]: captured with data_read[i] and equals the next-state busy bit of reg_read[i], so it is consistent with the bypassed data.
- Reset mid-operation: in-flight writes and busy_set in that cycle are discarded; no partial updates.
- No combinational path from any input to any output.

Test Plan:
- Reset check:
  - Stimulus: assert reset, then write 0xA5 to r3 via port 0 with reset still high.
  - Required: data_read, read_busy and busy_vector are all 0 throughout; reading r3 after release returns 0.
- Write and read all registers:
  - Stimulus: write r1..r31 with 10*r via port 0, then read r[k] on port 0 and r[31-k] on port 1.
  - Required: each read returns the stored value one cycle later; r0 reads 0 even after a write of 0xFFFF_FFFF.
- Bypass:
  - Stimulus: in one cycle, write r5=0x1234 on port 1 and read r5 on port 0.
  - Required: data_read port 0 = 0x1234 after that edge, not the old value.
- Write conflict:
  - Stimulus: same edge, port 0 writes r7=0x11 and port 1 writes r7=0x22.
  - Required: a later read of r7 returns 0x22; a same-cycle bypass read also returns 0x22.
- Scoreboard:
  - Stimulus: busy_set r9; next cycle write r9 with busy_set r9 again; next cycle write r9 only.
  - Required: busy_vector[9] = 1, then stays 1, then clears to 0.
  - Required: a read of r9 issued in the final cycle shows read_busy = 0.
- Async reset mid-stream:
  - Stimulus: pulse reset between clock edges while writes and busy_set are active.
  - Required: all outputs drop to 0 before the next edge; a following read of any register returns 0.

Source files
------------

// File: rtl/multiport_register_file.sv
// Multi-port CPU register file: N read / M write ports, same-edge write-to-read
// bypass, asynchronous clear and a per-register busy scoreboard for RAW detection.
module multiport_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] reg_read,
  input  logic [NUM_READ-1:0]            read_enable,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_read,
  output logic [NUM_READ-1:0]            read_busy,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] reg_write,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] data_write,
  input  logic [NUM_WRITE-1:0]           write_enable,
  input  logic                           busy_set,
  input  logic [ADDR_WIDTH-1:0]          busy_reg,
  output logic [NUM_REGS-1:0]            busy_vector
);

  logic [DATA_WIDTH-1:0] regs      [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_next [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;
  logic [DATA_WIDTH-1:0] rd_data   [NUM_READ];
  logic [NUM_READ-1:0]   rd_busy;

  // Register 0 and out-of-range addresses are never written, set or read.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  // Ascending port order makes the highest enabled write port win a conflict;
  // the busy set is applied after the clears so a new writer keeps the bit.
  always_comb begin
    regs_next = regs;
    busy_next = busy;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (write_enable[w] && addr_ok(reg_write[w*ADDR_WIDTH +: ADDR_WIDTH])) begin
        regs_next[reg_write[w*ADDR_WIDTH +: ADDR_WIDTH]] = data_write[w*DATA_WIDTH +: DATA_WIDTH];
        busy_next[reg_write[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (busy_set && addr_ok(busy_reg)) begin
      busy_next[busy_reg] = 1'b1;
    end
  end

  // Reads sample the post-write view, which is what provides the bypass.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rd_data[i] = '0;
      rd_busy[i] = 1'b0;
      if (addr_ok(reg_read[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        rd_data[i] = regs_next[reg_read[i*ADDR_WIDTH +: ADDR_WIDTH]];
        rd_busy[i] = busy_next[reg_read[i*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
      busy      <= '0;
      data_read <= '0;
      read_busy <= '0;
    end else begin
      regs <= regs_next;
      busy <= busy_next;
      for (int i = 0; i < NUM_READ; i++) begin
        if (read_enable[i]) begin
          data_read[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data[i];
          read_busy[i]                          <= rd_busy[i];
        end
      end
    end
  end

  assign busy_vector = busy;

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file: table of single-cycle vectors plus
// hand-written reset, write/read sweep and async-reset sequences.
module tb_multiport_register_file;

  logic        clk;
  logic        reset;
  logic [9:0]  reg_read;
  logic [1:0]  read_enable;
  logic [63:0] data_read;
  logic [1:0]  read_busy;
  logic [9:0]  reg_write;
  logic [63:0] data_write;
  logic [1:0]  write_enable;
  logic        busy_set;
  logic [4:0]  busy_reg;
  logic [31:0] busy_vector;

  int tests = 0;
  int fails = 0;

  multiport_register_file dut (
    .clk          (clk),
    .reset        (reset),
    .reg_read     (reg_read),
    .read_enable  (read_enable),
    .data_read    (data_read),
    .read_busy    (read_busy),
    .reg_write    (reg_write),
    .data_write   (data_write),
    .write_enable (write_enable),
    .busy_set     (busy_set),
    .busy_reg     (busy_reg),
    .busy_vector  (busy_vector)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  re;
    logic [4:0]  rd0, rd1;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        bset;
    logic [4:0]  breg;
    logic [31:0] d0, d1;
    logic [1:0]  rb;
    logic [31:0] bv;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] re, input logic [4:0] rd0, input logic [4:0] rd1,
                       input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic bset, input logic [4:0] breg);
    read_enable  = re;
    reg_read     = {rd1, rd0};
    write_enable = we;
    reg_write    = {wa1, wa0};
    data_write   = {wd1, wd0};
    busy_set     = bset;
    busy_reg     = breg;
  endtask

  task automatic idle();
    drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_data"}, data_read, 64'h0);
    check({name, "_rbusy"}, {62'h0, read_busy}, 64'h0);
    check({name, "_bvec"}, {32'h0, busy_vector}, 64'h0);
  endtask

  initial begin
    vecs[0]  = '{2'b11, 5'd5,  5'd6,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b0, 5'd0,  32'd50,    32'd60,    2'b00, 32'h0};
    vecs[1]  = '{2'b01, 5'd5,  5'd7,  2'b10, 5'd0,  32'h0,        5'd5,  32'h1234, 1'b0, 5'd0,  32'h1234,  32'd60,    2'b00, 32'h0};
    vecs[2]  = '{2'b11, 5'd7,  5'd5,  2'b11, 5'd7,  32'h11,       5'd7,  32'h22,   1'b0, 5'd0,  32'h22,    32'h1234,  2'b00, 32'h0};
    vecs[3]  = '{2'b01, 5'd7,  5'd0,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b0, 5'd0,  32'h22,    32'h1234,  2'b00, 32'h0};
    vecs[4]  = '{2'b11, 5'd9,  5'd0,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b1, 5'd9,  32'd90,    32'h0,     2'b01, 32'h200};
    vecs[5]  = '{2'b11, 5'd9,  5'd9,  2'b01, 5'd9,  32'h99,       5'd0,  32'h0,    1'b1, 5'd9,  32'h99,    32'h99,    2'b11, 32'h200};
    vecs[6]  = '{2'b11, 5'd9,  5'd9,  2'b10, 5'd0,  32'h0,        5'd9,  32'h9A,   1'b0, 5'd0,  32'h9A,    32'h9A,    2'b00, 32'h0};
    vecs[7]  = '{2'b11, 5'd0,  5'd31, 2'b01, 5'd31, 32'h5555,     5'd0,  32'h0,    1'b1, 5'd0,  32'h0,     32'h5555,  2'b00, 32'h0};
    vecs[8]  = '{2'b10, 5'd12, 5'd12, 2'b10, 5'd0,  32'h0,        5'd12, 32'hC0C0, 1'b1, 5'd12, 32'h0,     32'hC0C0,  2'b10, 32'h1000};
    vecs[9]  = '{2'b00, 5'd12, 5'd12, 2'b01, 5'd12, 32'h1,        5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     32'hC0C0,  2'b10, 32'h0};
    vecs[10] = '{2'b11, 5'd12, 5'd1,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b0, 5'd0,  32'h1,     32'd10,    2'b00, 32'h0};
    vecs[11] = '{2'b11, 5'd0,  5'd3,  2'b01, 5'd0,  32'hFFFF_FFFF, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,     32'd30,    2'b00, 32'h0};

    // Reset held while a write, read and busy_set are presented.
    reset = 1'b1;
    idle();
    #1;
    check_zero("reset_initial");
    @(negedge clk);
    drive(2'b11, 5'd3, 5'd3, 2'b01, 5'd3, 32'hA5, 5'd0, 32'h0, 1'b1, 5'd3);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check_zero("reset_held");
    end
    @(negedge clk);
    reset = 1'b0;
    drive(2'b11, 5'd3, 5'd3, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    check_zero("reset_r3_read");

    // Write r1..r31 = 10*r, then sweep reads on both ports.
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      drive(2'b00, 5'd0, 5'd0, 2'b01, 5'(r), 32'(10 * r), 5'd0, 32'h0, 1'b0, 5'd0);
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      drive(2'b11, 5'(k), 5'(31 - k), 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
      @(posedge clk);
      #1;
      check("sweep_p0", {32'h0, data_read[31:0]}, 64'(10 * k));
      check("sweep_p1", {32'h0, data_read[63:32]}, 64'(10 * (31 - k)));
    end

    // Table: bypass, conflict, scoreboard, hold and r0 vectors.
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      drive(vecs[v].re, vecs[v].rd0, vecs[v].rd1, vecs[v].we, vecs[v].wa0, vecs[v].wd0,
            vecs[v].wa1, vecs[v].wd1, vecs[v].bset, vecs[v].breg);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_d0", v), {32'h0, data_read[31:0]}, {32'h0, vecs[v].d0});
      check($sformatf("vec%0d_d1", v), {32'h0, data_read[63:32]}, {32'h0, vecs[v].d1});
      check($sformatf("vec%0d_rbusy", v), {62'h0, read_busy}, {62'h0, vecs[v].rb});
      check($sformatf("vec%0d_bvec", v), {32'h0, busy_vector}, {32'h0, vecs[v].bv});
    end

    // Build up nonzero state, then pulse reset between edges with traffic active.
    @(negedge clk);
    drive(2'b11, 5'd5, 5'd5, 2'b01, 5'd5, 32'h77, 5'd0, 32'h0, 1'b1, 5'd4);
    @(posedge clk);
    #1;
    check("pre_rst_d0", {32'h0, data_read[31:0]}, 64'h77);
    check("pre_rst_bvec", {32'h0, busy_vector}, 64'h10);
    @(negedge clk);
    drive(2'b11, 5'd6, 5'd5, 2'b01, 5'd6, 32'h66, 5'd0, 32'h0, 1'b1, 5'd8);
    #1;
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    #1;
    reset = 1'b0;
    drive(2'b11, 5'd5, 5'd6, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    check_zero("post_reset_read");
    @(negedge clk);
    drive(2'b11, 5'd4, 5'd31, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    check_zero("post_reset_read2");

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
